// File: rtl/clock_pkg.sv
// Shared definitions for the divided-clock monitor: FSM encoding, default
// half-periods and the bit positions used in err_period.
package clock_pkg;

    typedef enum logic [1:0] {
        ARM    = 2'd0,
        CHECK  = 2'd1,
        LOCKED = 2'd2
    } mon_state_e;

    localparam int DEF_HALF4 = 4;
    localparam int DEF_HALF2 = 8;
    localparam int DEF_HALF1 = 16;

    localparam int ERR_BIT4 = 2;
    localparam int ERR_BIT2 = 1;
    localparam int ERR_BIT1 = 0;

endpackage

// File: rtl/period_checker.sv
// Measures the half-period of one divided clock sampled as data on the fast
// clock, flagging wrong-length and stuck half-periods.
module period_checker #(
    parameter int HALF  = 4,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             x,
    output logic             toggle,
    output logic             period_err_event,
    output logic             armed,
    output logic [CNT_W-1:0] meas
);

    localparam logic [CNT_W-1:0] HALF_C  = CNT_W'(HALF);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             prev_q, prev_d;
    logic             armed_q, armed_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] meas_q, meas_d;

    always_comb begin
        prev_d           = x;
        armed_d          = armed_q;
        cnt_d            = cnt_q;
        meas_d           = meas_q;
        period_err_event = 1'b0;
        toggle           = (x != prev_q);
        if (toggle) begin
            // The first edge after reset only starts the count.
            armed_d = 1'b1;
            cnt_d   = CNT_W'(1);
            if (armed_q) begin
                meas_d           = cnt_q;
                period_err_event = (cnt_q != HALF_C);
            end
        end else if (armed_q) begin
            // Reaching HALF with no edge means the clock is late or stuck.
            if (cnt_q == HALF_C) period_err_event = 1'b1;
            if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q  <= 1'b0;
            armed_q <= 1'b0;
            cnt_q   <= '0;
            meas_q  <= '0;
        end else begin
            prev_q  <= prev_d;
            armed_q <= armed_d;
            cnt_q   <= cnt_d;
            meas_q  <= meas_d;
        end
    end

    assign armed = armed_q;
    assign meas  = meas_q;

endmodule

// File: rtl/clock_monitor.sv
// Fast-clock-side checker for the PHY divided clocks: period and phase checks,
// sticky error reporting and a lock FSM.
module clock_monitor
    import clock_pkg::*;
#(
    parameter int HALF4      = DEF_HALF4,
    parameter int HALF2      = DEF_HALF2,
    parameter int HALF1      = DEF_HALF1,
    parameter int LOCK_COUNT = 4,
    parameter int CNT_W      = 6
) (
    input  logic             clock32,
    input  logic             reset,
    input  logic             clock4,
    input  logic             clock2,
    input  logic             clock1,
    input  logic             clear_err,
    output logic             locked,
    output logic [2:0]       err_period,
    output logic             err_phase,
    output logic [CNT_W-1:0] meas4,
    output logic [CNT_W-1:0] meas2,
    output logic [CNT_W-1:0] meas1
);

    localparam int GOOD_W = $clog2(LOCK_COUNT + 1);

    logic [2:0]       clk_in, tog, armed, period_ev;
    logic [CNT_W-1:0] meas_arr [3];
    logic             phase_ev, err_event;

    // Channel index matches the err_period bit of that clock.
    assign clk_in = {clock4, clock2, clock1};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_chan
            localparam int HALF_G = (gi == ERR_BIT4) ? HALF4 :
                                    (gi == ERR_BIT2) ? HALF2 : HALF1;
            period_checker #(
                .HALF  (HALF_G),
                .CNT_W (CNT_W)
            ) u_chk (
                .clk              (clock32),
                .rst              (reset),
                .x                (clk_in[gi]),
                .toggle           (tog[gi]),
                .period_err_event (period_ev[gi]),
                .armed            (armed[gi]),
                .meas             (meas_arr[gi])
            );
        end
    endgenerate

    // A slower clock may only move on an edge shared with every faster one.
    assign phase_ev = (&armed) &&
        ((tog[ERR_BIT1] && !(tog[ERR_BIT2] && tog[ERR_BIT4])) ||
         (tog[ERR_BIT2] && !tog[ERR_BIT4]));
    assign err_event = (|period_ev) || phase_ev;

    mon_state_e        state_q, state_d;
    logic [GOOD_W-1:0] good_q, good_d;
    logic              locked_q, locked_d;
    logic [2:0]        err_period_q, err_period_d;
    logic              err_phase_q, err_phase_d;

    always_comb begin
        state_d      = state_q;
        good_d       = good_q;
        locked_d     = (state_q == LOCKED);
        err_period_d = (clear_err ? 3'b000 : err_period_q) | period_ev;
        err_phase_d  = (clear_err ? 1'b0 : err_phase_q) | phase_ev;
        case (state_q)
            ARM: begin
                if (&armed) begin
                    state_d = CHECK;
                    good_d  = '0;
                end
            end
            CHECK: begin
                if (err_event) begin
                    good_d = '0;
                end else if (tog[ERR_BIT1]) begin
                    good_d = good_q + 1'b1;
                    if (good_q == GOOD_W'(LOCK_COUNT - 1)) state_d = LOCKED;
                end
            end
            LOCKED: begin
                if (err_event) begin
                    state_d = CHECK;
                    good_d  = '0;
                end
            end
            default: begin
                state_d = ARM;
                good_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clock32 or posedge reset) begin
        if (reset) begin
            state_q      <= ARM;
            good_q       <= '0;
            locked_q     <= 1'b0;
            err_period_q <= 3'b000;
            err_phase_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            good_q       <= good_d;
            locked_q     <= locked_d;
            err_period_q <= err_period_d;
            err_phase_q  <= err_phase_d;
        end
    end

    assign locked     = locked_q;
    assign err_period = err_period_q;
    assign err_phase  = err_phase_q;
    assign meas4      = meas_arr[ERR_BIT4];
    assign meas2      = meas_arr[ERR_BIT2];
    assign meas1      = meas_arr[ERR_BIT1];

endmodule

// File: tb/tb_clock_monitor.sv
// Directed bench for clock_monitor: divider pattern, stuck clock, phase shift,
// wrong half-period, async reset and clear/set collision.
module tb_clock_monitor;

    localparam int CNT_W = 6;

    logic             clock32 = 1'b0;
    logic             reset;
    logic             clock4, clock2, clock1;
    logic             clear_err;
    logic             locked;
    logic [2:0]       err_period;
    logic             err_phase;
    logic [CNT_W-1:0] meas4, meas2, meas1;

    int ph;
    int n_checks;
    int n_pass;
    bit hold2, hold4, shift1, half4_5;

    clock_monitor #(
        .HALF4      (4),
        .HALF2      (8),
        .HALF1      (16),
        .LOCK_COUNT (4),
        .CNT_W      (CNT_W)
    ) dut (
        .clock32    (clock32),
        .reset      (reset),
        .clock4     (clock4),
        .clock2     (clock2),
        .clock1     (clock1),
        .clear_err  (clear_err),
        .locked     (locked),
        .err_period (err_period),
        .err_phase  (err_phase),
        .meas4      (meas4),
        .meas2      (meas2),
        .meas1      (meas1)
    );

    always #5 clock32 = ~clock32;

    // Applies the inputs for cycle ph, waits one edge, samples 1 time unit later.
    task automatic step();
        logic [31:0] p, pm1;
        p   = ph;
        pm1 = ph - 1;
        if (!hold4) clock4 = half4_5 ? ((ph / 5) % 2 == 0) : ~p[2];
        if (!hold2) clock2 = ~p[3];
        clock1 = shift1 ? ((ph <= 16) ? 1'b1 : ~pm1[4]) : ~p[4];
        @(posedge clock32);
        #1;
        ph++;
    endtask

    task automatic run_to(input int last);
        while (ph <= last) step();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clock4 = 1'b0; clock2 = 1'b0; clock1 = 1'b0;
        clear_err = 1'b0;
        repeat (2) @(posedge clock32);
        #1;
        reset = 1'b0;
        ph = 0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (locked !== 1'b0) $display("FAIL reset_locked: got %b want 0", locked); else n_pass++;
        n_checks++;
        if (err_period !== 3'b000) $display("FAIL reset_err_period: got %b want 000", err_period); else n_pass++;
        n_checks++;
        if (err_phase !== 1'b0) $display("FAIL reset_err_phase: got %b want 0", err_phase); else n_pass++;
        n_checks++;
        if ({meas4, meas2, meas1} !== '0) $display("FAIL reset_meas: got %0d/%0d/%0d want 0/0/0", meas4, meas2, meas1); else n_pass++;
        $display("reset: locked=%b err_period=%b err_phase=%b", locked, err_period, err_phase);
    endtask

    task automatic test_lock();
        run_to(64);
        n_checks++;
        if (locked !== 1'b0) $display("FAIL lock_early: got %b want 0 at ph 64", locked); else n_pass++;
        run_to(65);
        n_checks++;
        if (locked !== 1'b1) $display("FAIL lock_reached: got %b want 1 at ph 65", locked); else n_pass++;
        n_checks++;
        if (meas4 !== 6'd4 || meas2 !== 6'd8 || meas1 !== 6'd16)
            $display("FAIL lock_meas: got %0d/%0d/%0d want 4/8/16", meas4, meas2, meas1); else n_pass++;
        n_checks++;
        if (err_period !== 3'b000 || err_phase !== 1'b0)
            $display("FAIL lock_errs: got period=%b phase=%b want 000/0", err_period, err_phase); else n_pass++;
        $display("lock: locked=%b meas=%0d/%0d/%0d", locked, meas4, meas2, meas1);
    endtask

    task automatic test_stuck_clock2();
        hold2 = 1'b1;
        run_to(71);
        n_checks++;
        if (err_period !== 3'b000) $display("FAIL stuck_before: got %b want 000", err_period); else n_pass++;
        run_to(72);
        n_checks++;
        if (err_period !== 3'b010 || locked !== 1'b1)
            $display("FAIL stuck_detect: got period=%b locked=%b want 010/1", err_period, locked); else n_pass++;
        run_to(73);
        n_checks++;
        if (locked !== 1'b0) $display("FAIL stuck_unlock: got %b want 0", locked); else n_pass++;
        run_to(75);
        hold2 = 1'b0;
        run_to(144);
        n_checks++;
        if (locked !== 1'b0) $display("FAIL relock_early: got %b want 0 at ph 144", locked); else n_pass++;
        run_to(145);
        n_checks++;
        if (locked !== 1'b1 || err_period !== 3'b010 || err_phase !== 1'b0)
            $display("FAIL relock: got locked=%b period=%b phase=%b want 1/010/0", locked, err_period, err_phase); else n_pass++;
        clear_err = 1'b1;
        step();
        clear_err = 1'b0;
        n_checks++;
        if (err_period !== 3'b000) $display("FAIL stuck_clear: got %b want 000", err_period); else n_pass++;
        $display("stuck clock2: relocked, err_period=%b after clear", err_period);
    endtask

    task automatic test_phase_shift();
        do_reset();
        shift1 = 1'b1;
        run_to(15);
        n_checks++;
        if (err_period !== 3'b000) $display("FAIL shift_before: got %b want 000", err_period); else n_pass++;
        run_to(16);
        n_checks++;
        if (err_period !== 3'b001 || err_phase !== 1'b0)
            $display("FAIL shift_period: got period=%b phase=%b want 001/0", err_period, err_phase); else n_pass++;
        run_to(17);
        n_checks++;
        if (err_phase !== 1'b1) $display("FAIL shift_phase: got %b want 1", err_phase); else n_pass++;
        run_to(100);
        n_checks++;
        if (locked !== 1'b0) $display("FAIL shift_nolock: got %b want 0", locked); else n_pass++;
        shift1 = 1'b0;
        $display("phase shift: err_period=%b err_phase=%b locked=%b", err_period, err_phase, locked);
    endtask

    task automatic test_bad_half4();
        do_reset();
        half4_5 = 1'b1;
        run_to(5);
        n_checks++;
        if (meas4 !== 6'd5 || err_period[2] !== 1'b1)
            $display("FAIL half4_bad: got meas4=%0d err4=%b want 5/1", meas4, err_period[2]); else n_pass++;
        run_to(11);
        half4_5 = 1'b0;
        run_to(39);
        clear_err = 1'b1;
        step();
        clear_err = 1'b0;
        n_checks++;
        if (err_period !== 3'b000 || err_phase !== 1'b0)
            $display("FAIL half4_clear: got period=%b phase=%b want 000/0", err_period, err_phase); else n_pass++;
        run_to(64);
        n_checks++;
        if (locked !== 1'b0) $display("FAIL half4_lock_early: got %b want 0", locked); else n_pass++;
        run_to(65);
        n_checks++;
        if (locked !== 1'b1 || meas4 !== 6'd4)
            $display("FAIL half4_lock: got locked=%b meas4=%0d want 1/4", locked, meas4); else n_pass++;
        $display("clock4 half 5: recovered, locked=%b", locked);
    endtask

    task automatic test_async_reset();
        run_to(70);
        #3;
        reset = 1'b1;
        clock4 = 1'b0; clock2 = 1'b0; clock1 = 1'b0;
        #1;
        n_checks++;
        if (locked !== 1'b0 || err_period !== 3'b000 || err_phase !== 1'b0 || meas4 !== '0)
            $display("FAIL async_reset: got locked=%b period=%b phase=%b meas4=%0d want 0", locked, err_period, err_phase, meas4); else n_pass++;
        @(posedge clock32);
        #1;
        reset = 1'b0;
        ph = 0;
        run_to(40);
        n_checks++;
        if (err_period !== 3'b000 || err_phase !== 1'b0)
            $display("FAIL async_rearm: got period=%b phase=%b want 000/0", err_period, err_phase); else n_pass++;
        run_to(65);
        n_checks++;
        if (locked !== 1'b1) $display("FAIL async_relock: got %b want 1", locked); else n_pass++;
        $display("async reset: relocked=%b", locked);
    endtask

    task automatic test_clear_collision();
        run_to(67);
        n_checks++;
        if (err_period !== 3'b000) $display("FAIL collide_pre: got %b want 000", err_period); else n_pass++;
        hold4 = 1'b1;
        clear_err = 1'b1;
        step();
        hold4 = 1'b0;
        clear_err = 1'b0;
        n_checks++;
        if (err_period !== 3'b100 || locked !== 1'b1)
            $display("FAIL collide_set: got period=%b locked=%b want 100/1", err_period, locked); else n_pass++;
        step();
        n_checks++;
        if (locked !== 1'b0 || err_period !== 3'b100)
            $display("FAIL collide_unlock: got locked=%b period=%b want 0/100", locked, err_period); else n_pass++;
        $display("clear collision: err_period=%b", err_period);
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        hold2 = 1'b0; hold4 = 1'b0; shift1 = 1'b0; half4_5 = 1'b0;
        test_reset();
        test_lock();
        test_stuck_clock2();
        test_phase_shift();
        test_bad_half4();
        test_async_reset();
        test_clear_collision();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/clock_monitor.md
Name: clock_monitor

Overview:
- Checks the divided clocks produced by the PHY clock divider, from the fast-clock side.
- Runs on clock32 and samples clock4, clock2 and clock1 as ordinary data.
- Measures each half-period, checks the phase relation between the three clocks, and asserts `locked` after a run of consecutive good half-periods.
- Reports sticky period and phase errors for bring-up and for the verification bench.

Parameters:
- HALF4, 4: expected clock4 half-period, in clock32 cycles
- HALF2, 8: expected clock2 half-period, in clock32 cycles
- HALF1, 16: expected clock1 half-period, in clock32 cycles
- LOCK_COUNT, 4: consecutive good clock1 half-periods (all channels clean) required to lock
- CNT_W, 6: width of each period counter; must satisfy 2^CNT_W > HALF1+1

Ports:
- clock32, in, 1: sole clock; all logic on posedge
- reset, in, 1: asynchronous, active-high reset
- clock4, in, 1: divided clock under test, sampled as data
- clock2, in, 1: divided clock under test, sampled as data
- clock1, in, 1: divided clock under test, sampled as data
- clear_err, in, 1: synchronous clear of the sticky error flags
- locked, out, 1: all three clocks verified
- err_period, out, 3: sticky period errors; bit2=clock4, bit1=clock2, bit0=clock1
- err_phase, out, 1: sticky phase-relation error
- meas4, out, CNT_W: last measured clock4 half-period
- meas2, out, CNT_W: last measured clock2 half-period
- meas1, out, CNT_W: last measured clock1 half-period

Behaviour:
- Reset (async, active-high). Every flop clears:
  - outputs: locked=0, err_period=0, err_phase=0, meas*=0
  - internal: prev samples=0, counters=0, good count=0, FSM=ARM
- Sampling: each input is registered once into prev_x. A toggle is detected in cycle t when x != prev_x.
- Per channel x (HALF is that channel's parameter):
  - armed_x sets on the first toggle after reset.
  - Toggle while armed_x=1: meas_x<=cnt_x. If cnt_x!=HALF, set period error bit x. Then cnt_x<=1.
  - First toggle (armed_x=0): cnt_x<=1; no check is made.
  - No toggle while armed_x=1: if cnt_x==HALF, set period error bit x (stuck clock); otherwise cnt_x<=cnt_x+1, saturating at all-ones.
  - Example: toggles 4 cycles apart give cnt=4 at the second toggle, which passes for clock4.
- Phase rule: an error is flagged (err_phase set, event pulse to FSM) in any cycle where, once all channels are armed:
  - clock1 toggles while clock2 or clock4 does not toggle in the same cycle, or
  - clock2 toggles while clock4 does not toggle in the same cycle.
- Error event: any new period or phase violation in the current cycle.
  - It drives the FSM regardless of the sticky flags.
  - Sticky flags set on the event and clear only on clear_err or reset.
  - Set wins when clear_err coincides with a new event.
- FSM, states ARM, CHECK, LOCKED:
  - ARM: waits until all three channels are armed, then CHECK with good=0.
  - CHECK: each clock1 toggle with no error event increments good. Reaching good==LOCK_COUNT moves to LOCKED. An error event clears good and stays in CHECK.
  - LOCKED: locked=1 (registered, asserted the cycle after entry). An error event moves to CHECK with good=0, and locked drops the next cycle.
- Latency: one cycle from an input edge to detection, and one more cycle to the flag or output update.
- Reset mid-operation returns everything to the reset state. The first toggle after release is only re-armed, never checked.
- Simultaneous toggle and counter saturation: the toggle takes priority.

Decomposition:
- Shared package (clock_pkg):
  - FSM state encoding ARM=2'd0, CHECK=2'd1, LOCKED=2'd2
  - default half-period constants 4/8/16
  - err_period bit indices
- One sub-module, period_checker, instantiated three times. It contains the sample flop, the armed flag, cnt and meas, and takes HALF and CNT_W as parameters. Outputs: toggle, period_err_event.
- The top level holds the phase checking, the FSM and the sticky flags.

Test Plan:
- Drive the real divider pattern (clock4/2/1 toggling every 4/8/16 cycles, all rising together) -> locked=1 after the 1st arming toggle plus 4 good clock1 half-periods; err_*=0; meas4=4, meas2=8, meas1=16.
- While locked, hold clock2 constant for 10 cycles -> err_period=3'b010 at cnt2==8; locked falls the next cycle; it relocks after 4 clean clock1 half-periods once clock2 resumes correctly; err_period stays 3'b010 until clear_err.
- Shift clock1 by one cycle relative to clock2/clock4 -> err_phase=1 plus err_period[0]=1; locked never asserts.
- Drive clock4 with a half-period of 5 -> meas4=5, err_period[2]=1; pulse clear_err after correcting it -> err_period=0 and lock is reached.
- Assert reset asynchronously mid-lock, between clock edges -> locked=0 and all flags=0 immediately; after release the first edges only arm, with no false errors.
- Assert clear_err in the same cycle as a new clock4 period error -> err_period[2] stays 1.
